// File: rtl/sar_pkg.sv
// Shared SAR constants: LFSR taps, default seed and default resolution.
package sar_pkg;

    localparam int unsigned SAR_N_BITS = 8;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? LFSR_SEED_DEF : s;
    endfunction

endpackage

// File: rtl/sar_lfsr16.sv
// 16-bit Fibonacci LFSR; an all-zero seed is replaced by the default seed.
module sar_lfsr16
    import sar_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_state
);

    localparam logic [15:0] P_SEED = lfsr_seed_fix(SEED);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= P_SEED;
        end else if (i_en) begin
            r_state <= {w_fb, r_state[15:1]};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/sar_afe_emu.sv
// Digital stand-in for the SAR analog front end: hold register, offset,
// optional dither and a fixed-latency comparator answering DAC trial codes.
module sar_afe_emu
    import sar_pkg::*;
#(
    parameter int          N_BITS    = SAR_N_BITS,
    parameter int          COMP_LAT  = 1,
    parameter bit          NOISE_EN  = 1'b0,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sample,
    input  logic [N_BITS-1:0] i_vin,
    input  logic [3:0]        i_offset,
    input  logic [N_BITS-1:0] i_dac,
    output logic              o_comp,
    output logic [N_BITS-1:0] o_held,
    output logic [15:0]       o_nsamples
);

    localparam logic [N_BITS-1:0] P_MAX = '1;

    logic [N_BITS-1:0]   r_held;
    logic [15:0]         r_nsamples;
    logic [COMP_LAT-1:0] r_pipe;

    logic [1:0]          w_dither;
    logic [N_BITS+1:0]   w_eff;
    logic [N_BITS-1:0]   w_sat;
    logic                w_raw;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_held     <= '0;
            r_nsamples <= '0;
        end else if (i_sample) begin
            r_held     <= i_vin;
            r_nsamples <= r_nsamples + 16'd1;
        end
    end

    generate
        if (NOISE_EN) begin : g_noise
            logic [15:0] w_lfsr;
            logic        w_unused_lfsr;

            sar_lfsr16 #(
                .SEED (LFSR_SEED)
            ) u_lfsr (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_en    (1'b1),
                .o_state (w_lfsr)
            );

            assign w_unused_lfsr = ^w_lfsr[15:2];

            // 00 -> -1, 01/10 -> 0, 11 -> +1 (two's complement, 2 bits)
            always_comb begin
                w_dither = 2'b00;
                case (w_lfsr[1:0])
                    2'b00:   w_dither = 2'b11;
                    2'b11:   w_dither = 2'b01;
                    default: w_dither = 2'b00;
                endcase
            end
        end else begin : g_quiet
            assign w_dither = 2'b00;
        end
    endgenerate

    // Headroom of two bits keeps the sum exact before saturation
    assign w_eff = {2'b00, r_held}
                 + {{(N_BITS-2){i_offset[3]}}, i_offset}
                 + {{N_BITS{w_dither[1]}}, w_dither};

    always_comb begin
        w_sat = w_eff[N_BITS-1:0];
        if (w_eff[N_BITS+1]) begin
            w_sat = '0;
        end else if (w_eff[N_BITS]) begin
            w_sat = P_MAX;
        end
    end

    assign w_raw = (w_sat >= i_dac);

    generate
        if (COMP_LAT == 1) begin : g_lat1
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= w_raw;
                end
            end
        end else begin : g_latn
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[COMP_LAT-2:0], w_raw};
                end
            end
        end
    endgenerate

    assign o_comp     = r_pipe[COMP_LAT-1];
    assign o_held     = r_held;
    assign o_nsamples = r_nsamples;

endmodule

// File: tb/tb_sar_afe_emu.sv
// Scoreboard bench for sar_afe_emu: three instances (latency 1, 3, dithered)
// driven by a bench-side SAR back end.
module tb_sar_afe_emu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample;
    logic [7:0] vin;
    logic [3:0] offset;
    logic [7:0] dac;

    logic        comp1, comp3, compn;
    logic [7:0]  held1, held3, heldn;
    logic [15:0] ns1, ns3, nsn;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_exp[$];

    always #5 clk = ~clk;

    sar_afe_emu #(.N_BITS(8), .COMP_LAT(1), .NOISE_EN(1'b0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample), .i_vin(vin),
        .i_offset(offset), .i_dac(dac), .o_comp(comp1), .o_held(held1),
        .o_nsamples(ns1)
    );

    sar_afe_emu #(.N_BITS(8), .COMP_LAT(3), .NOISE_EN(1'b0)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample), .i_vin(vin),
        .i_offset(offset), .i_dac(dac), .o_comp(comp3), .o_held(held3),
        .o_nsamples(ns3)
    );

    sar_afe_emu #(.N_BITS(8), .COMP_LAT(2), .NOISE_EN(1'b1)) dutn (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample), .i_vin(vin),
        .i_offset(offset), .i_dac(dac), .o_comp(compn), .o_held(heldn),
        .o_nsamples(nsn)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff(input int h, input logic [3:0] off);
        int v;
        v = h + int'($signed(off));
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            0:       return comp1;
            1:       return comp3;
            default: return compn;
        endcase
    endfunction

    task automatic convert(input int sel, input int lat, input logic [7:0] v,
                           input logic [3:0] off, output logic [7:0] code);
        offset = off;
        vin    = v;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        code   = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            dac = code | (8'h01 << b);
            repeat (lat) tick();
            if (pick(sel)) code = dac;
        end
    endtask

    logic [7:0] cv_vin[8] = '{8'hA5, 8'h00, 8'hFF, 8'h10,
                              8'h02, 8'hFF, 8'h00, 8'h7E};
    logic [3:0] cv_off[8] = '{4'h0, 4'h0, 4'h0, 4'h3,
                              4'h8, 4'h7, 4'h8, 4'hF};

    initial begin
        logic [7:0]  code;
        logic [31:0] e;
        rst_n  = 1'b0;
        sample = 1'b0;
        vin    = 8'h00;
        offset = 4'h0;
        dac    = 8'h00;
        #12;
        chk("rst_comp", {31'd0, comp1}, 32'd0);
        chk("rst_held", {24'd0, held1}, 32'd0);
        chk("rst_ns", {16'd0, ns1}, 32'd0);
        rst_n = 1'b1;

        // build some state, then reset mid-cycle
        vin    = 8'h55;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        chk("pre_held", {24'd0, held1}, 32'h55);
        chk("pre_ns", {16'd0, ns1}, 32'd1);
        tick();
        chk("pre_comp", {31'd0, comp1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_comp", {31'd0, comp1}, 32'd0);
        chk("async_held", {24'd0, held1}, 32'd0);
        chk("async_ns", {16'd0, ns1}, 32'd0);
        chk("async_lfsr", {16'd0, dutn.g_noise.u_lfsr.o_state}, 32'hACE1);
        #1 rst_n = 1'b1;
        chk("rel_lfsr", {16'd0, dutn.g_noise.u_lfsr.o_state}, 32'hACE1);

        // held=0, offset=-8 saturates to 0; 0 >= 0 is true
        offset = 4'h8;
        dac    = 8'h00;
        tick();
        chk("sat_low", {31'd0, comp1}, 32'd1);
        dac = 8'h01;
        tick();
        chk("sat_low_1", {31'd0, comp1}, 32'd0);
        offset = 4'h0;

        // basic compare
        vin    = 8'h80;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        chk("basic_held", {24'd0, held1}, 32'h80);
        dac = 8'h7F; tick(); chk("basic_7f", {31'd0, comp1}, 32'd1);
        dac = 8'h80; tick(); chk("basic_80", {31'd0, comp1}, 32'd1);
        dac = 8'h81; tick(); chk("basic_81", {31'd0, comp1}, 32'd0);

        // sample collides with compare: decision uses old held
        vin    = 8'h10;
        sample = 1'b1;
        dac    = 8'h50;
        tick();
        sample = 1'b0;
        chk("coll_comp", {31'd0, comp1}, 32'd1);
        chk("coll_held", {24'd0, held1}, 32'h10);
        tick();
        chk("coll_next", {31'd0, comp1}, 32'd0);

        // held=FF, offset=+7 must saturate, not wrap
        vin    = 8'hFF;
        offset = 4'h7;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        dac = 8'hFF;
        tick();
        chk("sat_high", {31'd0, comp1}, 32'd1);
        offset = 4'h0;

        // latency 3: alternate trial codes around held=0x40
        vin    = 8'h40;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        q_exp.delete();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                dac = (c % 2 == 0) ? 8'h3F : 8'h41;
                q_exp.push_back((eff(8'h40, 4'h0) >= int'(dac)) ? 32'd1 : 32'd0);
            end
            tick();
            if (c >= 2) begin
                chk($sformatf("lat3_%0d", c - 2), {31'd0, comp3},
                    q_exp.pop_front());
            end
        end

        // full conversions through both latencies
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                q_exp.push_back(32'(eff(int'(cv_vin[i]), cv_off[i])));
                convert(s, (s == 0) ? 1 : 3, cv_vin[i], cv_off[i], code);
                e = q_exp.pop_front();
                chk($sformatf("conv_l%0d_%0d", s, i), {24'd0, code}, e);
            end
        end
        offset = 4'h0;

        // dithered instance after a fresh reset
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("noise_seed", {16'd0, dutn.g_noise.u_lfsr.o_state}, 32'hACE1);
        for (int i = 0; i < 1000; i++) begin
            convert(2, 2, 8'h80, 4'h0, code);
            chk($sformatf("dither_%0d", i),
                {31'd0, (code == 8'h7F || code == 8'h80 || code == 8'h81)},
                32'd1);
        end
        chk("noise_ns", {16'd0, nsn}, 32'd1000);
        chk("noise_held", {24'd0, heldn}, 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
